vga_pattern_gen: RTL and testbench

Parametrised test-pattern source for the SDRAM/VGA path. It generates one frame of pixel data per start request, paced by the downstream write-FIFO's wr_en pull. It adds configurable data width and frame geometry, four pattern modes, continuous (free-running) frames, abort, and frame status outputs. It sits between the control/host side (start toggle) and the SDRAM write buffer.

---
 rtl/vga_pattern_gen.sv | 193 +++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen
//   Test-pattern source for the SDRAM/VGA write path. Each start request
//   (a toggle on start_i) produces one frame of H_ACTIVE x V_ACTIVE pixels,
//   paced by the downstream FIFO pulling with wr_en. Continuous mode chains
//   frames, abort_i drops the current frame without counting it.
//
// Ports
//   clk, rst_n      system clock, asynchronous active-low reset
//   start_i         toggle-encoded start request (may be asynchronous)
//   mode_i[1:0]     pattern select: 0 linear ramp, 1 horizontal ramp,
//                   2 checkerboard, 3 flat seed
//   cont_i          continuous frames when high at end of frame
//   abort_i         synchronous abort back to idle
//   wr_en           downstream pull, one pixel per high cycle
//   data_en, dout   pixel strobe and data, one cycle after the pull
//   busy_o          frame in progress
//   frame_done_o    one-cycle pulse per completed frame
//   frame_cnt_o     completed-frame counter (wraps)
//
// state     | meaning
// ----------+--------------------------------------------------------
// IDLE      | waiting for a start toggle
// PRE_WRITE | latch mode, clear pixel counters (one cycle)
// WRITING   | emit one pixel per wr_en cycle until the frame is full
// COMPLETE  | count the frame, advance seed, loop or return to idle
module vga_pattern_gen #(
  parameter int DATA_W      = 16,
  parameter int H_ACTIVE    = 1024,
  parameter int V_ACTIVE    = 768,
  parameter int SPAN_NUM    = 1,
  parameter int CHECK_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [1:0]        mode_i,
  input  logic              cont_i,
  input  logic              abort_i,
  input  logic              wr_en,
  output logic              data_en,
  output logic [DATA_W-1:0] dout,
  output logic              busy_o,
  output logic              frame_done_o,
  output logic [7:0]        frame_cnt_o
);

  localparam int FRAME = H_ACTIVE * V_ACTIVE;
  localparam int X_W   = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int Y_W   = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam int IDX_W = (FRAME > 1) ? $clog2(FRAME) : 1;
  // Wide enough to hold x, y and the checkerboard select bit, so small
  // frames with a large tile simply see a constant-zero select bit.
  localparam int CW_XY = (X_W > Y_W) ? X_W : Y_W;
  localparam int CW    = (CW_XY > CHECK_SHIFT + 1) ? CW_XY : CHECK_SHIFT + 1;

  localparam logic [X_W-1:0]    X_LAST = X_W'(H_ACTIVE - 1);
  localparam logic [Y_W-1:0]    Y_LAST = Y_W'(V_ACTIVE - 1);
  localparam logic [DATA_W-1:0] SPAN   = DATA_W'(SPAN_NUM);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_PRE      = 2'd1;
  localparam logic [1:0] ST_WRITING  = 2'd2;
  localparam logic [1:0] ST_COMPLETE = 2'd3;

  logic              start_d1_q, start_d1_d;
  logic              start_d2_q, start_d2_d;
  logic              start_d3_q, start_d3_d;
  logic [1:0]        state_q, state_d;
  logic [1:0]        mode_q, mode_d;
  logic [X_W-1:0]    x_q, x_d;
  logic [Y_W-1:0]    y_q, y_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] seed_q, seed_d;
  logic              data_en_q, data_en_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              frame_done_q, frame_done_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic              start_pulse;
  logic              x_bit, y_bit;
  logic              last_pix;
  logic [DATA_W-1:0] pix_val;

  // Edge detect on the synchronised toggle: any change is one request.
  assign start_pulse = start_d2_q ^ start_d3_q;

  assign x_bit    = |((CW'(x_q) >> CHECK_SHIFT) & CW'(1));
  assign y_bit    = |((CW'(y_q) >> CHECK_SHIFT) & CW'(1));
  assign last_pix = (x_q == X_LAST) && (y_q == Y_LAST);

  always_comb begin
    pix_val = seed_q;
    case (mode_q)
      2'd0:    pix_val = seed_q + DATA_W'(idx_q);
      2'd1:    pix_val = seed_q + DATA_W'(x_q);
      2'd2:    pix_val = (x_bit ^ y_bit) ? '1 : '0;
      default: pix_val = seed_q;
    endcase
  end

  always_comb begin
    start_d1_d   = start_i;
    start_d2_d   = start_d1_q;
    start_d3_d   = start_d2_q;
    state_d      = state_q;
    mode_d       = mode_q;
    x_d          = x_q;
    y_d          = y_q;
    idx_d        = idx_q;
    seed_d       = seed_q;
    dout_d       = dout_q;
    frame_cnt_d  = frame_cnt_q;
    data_en_d    = 1'b0;
    frame_done_d = 1'b0;

    if (abort_i) begin
      // Abort beats every transition, including the COMPLETE bookkeeping.
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start_pulse) state_d = ST_PRE;
        end
        ST_PRE: begin
          mode_d  = mode_i;
          x_d     = '0;
          y_d     = '0;
          idx_d   = '0;
          state_d = ST_WRITING;
        end
        ST_WRITING: begin
          if (wr_en) begin
            data_en_d = 1'b1;
            dout_d    = pix_val;
            idx_d     = idx_q + IDX_W'(1);
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = (y_q == Y_LAST) ? '0 : y_q + Y_W'(1);
            end else begin
              x_d = x_q + X_W'(1);
            end
            if (last_pix) state_d = ST_COMPLETE;
          end
        end
        default: begin
          frame_done_d = 1'b1;
          frame_cnt_d  = frame_cnt_q + 8'd1;
          seed_d       = seed_q + SPAN;
          state_d      = cont_i ? ST_PRE : ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_d1_q   <= 1'b0;
      start_d2_q   <= 1'b0;
      start_d3_q   <= 1'b0;
      state_q      <= ST_IDLE;
      mode_q       <= 2'd0;
      x_q          <= '0;
      y_q          <= '0;
      idx_q        <= '0;
      seed_q       <= '0;
      data_en_q    <= 1'b0;
      dout_q       <= '0;
      frame_done_q <= 1'b0;
      frame_cnt_q  <= 8'd0;
    end else begin
      start_d1_q   <= start_d1_d;
      start_d2_q   <= start_d2_d;
      start_d3_q   <= start_d3_d;
      state_q      <= state_d;
      mode_q       <= mode_d;
      x_q          <= x_d;
      y_q          <= y_d;
      idx_q        <= idx_d;
      seed_q       <= seed_d;
      data_en_q    <= data_en_d;
      dout_q       <= dout_d;
      frame_done_q <= frame_done_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign data_en      = data_en_q;
  assign dout         = dout_q;
  assign busy_o       = (state_q != ST_IDLE);
  assign frame_done_o = frame_done_q;
  assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: a 4x2 instance (ramps, flat, continuous,
// abort, reset) and a 16x16 instance (checkerboard). Expected pixels come
// from a frame-level model pushed into per-instance queues.
module tb_vga_pattern_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;

  logic        start_a = 1'b0, cont_a = 1'b0, abort_a = 1'b0, wr_en_a = 1'b0;
  logic [1:0]  mode_a = 2'd0;
  logic        data_en_a, busy_a, done_a;
  logic [15:0] dout_a;
  logic [7:0]  cnt_a;

  logic        start_b = 1'b0, cont_b = 1'b0, abort_b = 1'b0, wr_en_b = 1'b0;
  logic [1:0]  mode_b = 2'd0;
  logic        data_en_b, busy_b, done_b;
  logic [15:0] dout_b;
  logic [7:0]  cnt_b;

  vga_pattern_gen #(.DATA_W(16), .H_ACTIVE(4), .V_ACTIVE(2), .SPAN_NUM(1),
                    .CHECK_SHIFT(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .start_i(start_a), .mode_i(mode_a),
    .cont_i(cont_a), .abort_i(abort_a), .wr_en(wr_en_a),
    .data_en(data_en_a), .dout(dout_a), .busy_o(busy_a),
    .frame_done_o(done_a), .frame_cnt_o(cnt_a));

  vga_pattern_gen #(.DATA_W(16), .H_ACTIVE(16), .V_ACTIVE(16), .SPAN_NUM(1),
                    .CHECK_SHIFT(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .start_i(start_b), .mode_i(mode_b),
    .cont_i(cont_b), .abort_i(abort_b), .wr_en(wr_en_b),
    .data_en(data_en_b), .dout(dout_b), .busy_o(busy_b),
    .frame_done_o(done_b), .frame_cnt_o(cnt_b));

  int checks = 0;
  int errors = 0;

  logic [15:0] exp_a[$];
  logic [15:0] exp_b[$];
  logic        wr_prev_a, wr_prev_b;
  logic [15:0] last_a = 16'h0, last_b = 16'h0;
  int          dones_a = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Frame-level pixel model: pixel i of a frame of width h.
  function automatic logic [15:0] pix(input int mode, input int seed, input int i, input int h);
    int x, y;
    x = i % h;
    y = i / h;
    case (mode)
      0:       return 16'(seed + i);
      1:       return 16'(seed + x);
      2:       return ((((x >> 3) ^ (y >> 3)) & 1) == 1) ? 16'hFFFF : 16'h0000;
      default: return 16'(seed);
    endcase
  endfunction

  task automatic push_frame_a(input int mode, input int seed);
    for (int i = 0; i < 8; i++) exp_a.push_back(pix(mode, seed, i, 4));
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_prev_a <= 1'b0;
      wr_prev_b <= 1'b0;
    end else begin
      wr_prev_a <= wr_en_a;
      wr_prev_b <= wr_en_b;
    end
  end

  // Single compare process: every pixel strobe must follow a pull and match
  // the model queue; between strobes dout must hold.
  always @(negedge clk) begin
    logic [15:0] e;
    if (!rst_n) begin
      last_a = 16'h0;
      last_b = 16'h0;
    end else begin
      if (data_en_a) begin
        chk("a_pace", 32'(wr_prev_a), 32'd1);
        if (exp_a.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_extra_pulse dout=%0h expected no strobe", dout_a);
        end else begin
          e = exp_a.pop_front();
          chk("a_dout", 32'(dout_a), 32'(e));
        end
        last_a = dout_a;
      end else begin
        chk("a_hold", 32'(dout_a), 32'(last_a));
      end
      if (done_a) dones_a++;

      if (data_en_b) begin
        chk("b_pace", 32'(wr_prev_b), 32'd1);
        if (exp_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_extra_pulse dout=%0h expected no strobe", dout_b);
        end else begin
          e = exp_b.pop_front();
          chk("b_dout", 32'(dout_b), 32'(e));
        end
        last_b = dout_b;
      end else begin
        chk("b_hold", 32'(dout_b), 32'(last_b));
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset;
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    abort_a = 1'b0;
    cont_a  = 1'b0;
    #1;
    chk("rst_data_en", 32'(data_en_a), 32'd0);
    chk("rst_dout", 32'(dout_a), 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    tick;
    tick;
    exp_a.delete();
    exp_b.delete();
    rst_n = 1'b1;
    tick;
  endtask

  task automatic wait_pulse_a(input int limit, output int cyc);
    cyc = 0;
    while (!data_en_a && cyc < limit) begin
      tick;
      cyc++;
    end
  endtask

  task automatic wait_done_a(input int limit);
    int cyc = 0;
    while (!done_a && cyc < limit) begin
      tick;
      cyc++;
    end
    chk("a_done_timeout", 32'(done_a), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc, first, n, ones, frames, run, busy_drop, d0, busy_seen;
    logic seen;
    logic [15:0] lastd, px8;
    logic [15:0] got[$];
    int gaps[$];

    do_reset;

    // 1: linear ramp, constant pull, latency and frame pulse
    mode_a = 2'd0; wr_en_a = 1'b1;
    push_frame_a(0, 0);
    start_a = ~start_a;
    wait_pulse_a(20, cyc);
    chk("t1_latency", 32'(cyc), 32'd5);
    chk("t1_first_dout", 32'(dout_a), 32'd0);
    chk("t1_busy", 32'(busy_a), 32'd1);
    first = cyc;
    lastd = dout_a;
    while (!done_a && cyc < 60) begin
      tick;
      cyc++;
      if (data_en_a) lastd = dout_a;
    end
    chk("t1_done_seen", 32'(done_a), 32'd1);
    chk("t1_done_gap", 32'(cyc - first), 32'd8);
    chk("t1_last_dout", 32'(lastd), 32'd7);
    chk("t1_cnt", 32'(cnt_a), 32'd1);
    chk("t1_busy_after", 32'(busy_a), 32'd0);
    tick;
    chk("t1_done_one_cycle", 32'(done_a), 32'd0);
    chk("t1_queue", 32'(exp_a.size()), 32'd0);

    // 2: second frame carries seed 1
    push_frame_a(0, 1);
    start_a = ~start_a;
    wait_pulse_a(20, cyc);
    chk("t2_first_dout", 32'(dout_a), 32'd1);
    wait_done_a(40);
    chk("t2_cnt", 32'(cnt_a), 32'd2);
    tick;
    chk("t2_queue", 32'(exp_a.size()), 32'd0);

    // 3: horizontal ramp with alternating pull
    do_reset;
    mode_a = 2'd1; wr_en_a = 1'b0;
    push_frame_a(1, 0);
    start_a = ~start_a;
    cyc = 0;
    got.delete();
    while (!done_a && cyc < 80) begin
      tick;
      cyc++;
      wr_en_a = ~wr_en_a;
      if (data_en_a) got.push_back(dout_a);
    end
    chk("t3_done_seen", 32'(done_a), 32'd1);
    chk("t3_pulses", 32'(got.size()), 32'd8);
    for (int i = 0; i < got.size(); i++) chk("t3_seq", 32'(got[i]), 32'(i % 4));
    chk("t3_cnt", 32'(cnt_a), 32'd1);
    wr_en_a = 1'b1;
    tick;
    chk("t3_queue", 32'(exp_a.size()), 32'd0);

    // 4: checkerboard on the 16x16 instance
    mode_b = 2'd2; wr_en_b = 1'b1;
    for (int i = 0; i < 256; i++) exp_b.push_back(pix(2, 0, i, 16));
    start_b = ~start_b;
    n = 0; ones = 0; cyc = 0; px8 = 16'h0;
    while (!done_b && cyc < 400) begin
      tick;
      cyc++;
      if (data_en_b) begin
        if (n == 8) px8 = dout_b;
        if (dout_b == 16'hFFFF) ones++;
        n++;
      end
    end
    chk("t4_done_seen", 32'(done_b), 32'd1);
    chk("t4_pulses", 32'(n), 32'd256);
    chk("t4_ones", 32'(ones), 32'd128);
    chk("t4_px8", 32'(px8), 32'hFFFF);
    chk("t4_cnt", 32'(cnt_b), 32'd1);
    tick;
    chk("t4_queue", 32'(exp_b.size()), 32'd0);

    // 5: continuous flat frames, cont dropped during the third
    do_reset;
    mode_a = 2'd3; cont_a = 1'b1; wr_en_a = 1'b1;
    push_frame_a(3, 0);
    push_frame_a(3, 1);
    push_frame_a(3, 2);
    start_a = ~start_a;
    frames = 0; run = 0; seen = 1'b0; busy_drop = 0; cyc = 0;
    gaps.delete();
    while (frames < 3 && cyc < 200) begin
      tick;
      cyc++;
      if (data_en_a) begin
        if (seen && run > 0) gaps.push_back(run);
        seen = 1'b1;
        run = 0;
      end else if (seen) begin
        run++;
      end
      if (seen && !busy_a && !done_a) busy_drop++;
      if (done_a) begin
        frames++;
        if (frames == 2) cont_a = 1'b0;
      end
    end
    chk("t5_frames", 32'(frames), 32'd3);
    chk("t5_gap_count", 32'(gaps.size()), 32'd2);
    foreach (gaps[i]) chk("t5_gap_len", 32'(gaps[i]), 32'd2);
    chk("t5_busy_drop", 32'(busy_drop), 32'd0);
    chk("t5_cnt", 32'(cnt_a), 32'd3);
    busy_seen = 0;
    repeat (6) begin
      tick;
      if (busy_a) busy_seen++;
    end
    chk("t5_idle_after", 32'(busy_seen), 32'd0);
    chk("t5_queue", 32'(exp_a.size()), 32'd0);

    // 6a: abort after 3 pixels
    mode_a = 2'd0;
    push_frame_a(0, 3);
    d0 = dones_a;
    start_a = ~start_a;
    n = 0; cyc = 0;
    while (n < 3 && cyc < 40) begin
      tick;
      cyc++;
      if (data_en_a) n++;
    end
    chk("t6_pre_abort_pulses", 32'(n), 32'd3);
    abort_a = 1'b1;
    tick;
    abort_a = 1'b0;
    exp_a.delete();
    chk("t6_abort_data_en", 32'(data_en_a), 32'd0);
    chk("t6_abort_busy", 32'(busy_a), 32'd0);
    repeat (4) tick;
    chk("t6_abort_no_done", 32'(dones_a - d0), 32'd0);
    chk("t6_abort_cnt", 32'(cnt_a), 32'd3);

    // 6b: restart repeats seed 3; toggle mid-frame is ignored
    push_frame_a(0, 3);
    start_a = ~start_a;
    wait_pulse_a(20, cyc);
    chk("t6_restart_dout", 32'(dout_a), 32'd3);
    tick;
    tick;
    start_a = ~start_a;
    wait_done_a(40);
    chk("t6_restart_cnt", 32'(cnt_a), 32'd4);
    busy_seen = 0;
    repeat (10) begin
      tick;
      if (busy_a) busy_seen++;
    end
    chk("t6_toggle_ignored", 32'(busy_seen), 32'd0);
    chk("t6_queue", 32'(exp_a.size()), 32'd0);

    // 6c: asynchronous reset mid-frame
    push_frame_a(0, 4);
    start_a = ~start_a;
    n = 0; cyc = 0;
    while (n < 2 && cyc < 40) begin
      tick;
      cyc++;
      if (data_en_a) n++;
    end
    chk("t6_pre_reset_dout", 32'(dout_a), 32'd5);
    do_reset;
    busy_seen = 0;
    repeat (8) begin
      tick;
      if (busy_a || data_en_a) busy_seen++;
    end
    chk("t6_reset_no_restart", 32'(busy_seen), 32'd0);
    chk("t6_queue_final", 32'(exp_a.size()), 32'd0);
    chk("b_queue_final", 32'(exp_b.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
